// File: rtl/dmem_responder.sv
// Data-memory responder: single-port word array behind a one-entry store buffer, fixed-latency loads.
// Optional DMEM_FWD_EN: loads hitting the buffered address take sb_data instead of stalling.
module dmem_responder #(
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [29:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        n_stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err_oob
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              busy, hazard, accept, load_acc, store_acc, oob, sb_hit, mem_we;
  logic [ADDR_W-1:0] req_idx;

  logic              sb_valid_q, sb_valid_d;
  logic [ADDR_W-1:0] sb_addr_q, sb_addr_d;
  logic [31:0]       sb_data_q, sb_data_d;

  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       ram_rd_q;
  logic              vld0_q, zero_q;
  logic [31:0]       load_data, out_data;
  logic              out_vld;
  logic [31:0]       rdata_hold_q;
  logic              err_oob_q;

  assign req_idx = req_addr[ADDR_W-1:0];
  assign oob     = |req_addr[29:ADDR_W];
  assign sb_hit  = sb_valid_q && (sb_addr_q == req_idx);

`ifdef DMEM_FWD_EN
  assign hazard = 1'b0;
`else
  assign hazard = req_valid && !req_we && sb_hit;
`endif

  assign n_stall   = !busy && !hazard;
  assign accept    = req_valid && n_stall;
  assign load_acc  = accept && !req_we;
  assign store_acc = accept && req_we;
  // The single port goes to a load acceptance first; otherwise the buffer drains.
  assign mem_we    = sb_valid_q && !load_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (load_acc && (RD_LAT > 1)) begin
          state_d = S_WAIT;
          cnt_d   = LAT_M1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_WAIT);
  end

  always_comb begin
    sb_valid_d = sb_valid_q;
    sb_addr_d  = sb_addr_q;
    sb_data_d  = sb_data_q;
    if (mem_we) sb_valid_d = 1'b0;
    if (store_acc && !oob) begin
      sb_valid_d = 1'b1;
      sb_addr_d  = req_idx;
      sb_data_d  = req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_valid_q <= 1'b0;
      sb_addr_q  <= '0;
      sb_data_q  <= '0;
      err_oob_q  <= 1'b0;
    end else begin
      sb_valid_q <= sb_valid_d;
      sb_addr_q  <= sb_addr_d;
      sb_data_q  <= sb_data_d;
      err_oob_q  <= err_oob_q || (accept && oob);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)   mem[sb_addr_q] <= sb_data_q;
    if (load_acc) ram_rd_q <= mem[req_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld0_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      vld0_q <= load_acc;
      if (load_acc) zero_q <= oob;
    end
  end

`ifdef DMEM_FWD_EN
  logic        fwd_q;
  logic [31:0] fwd_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else if (load_acc) begin
      fwd_q      <= sb_hit;
      fwd_data_q <= sb_data_q;
    end
  end

  assign load_data = zero_q ? 32'd0 : (fwd_q ? fwd_data_q : ram_rd_q);
`else
  assign load_data = zero_q ? 32'd0 : ram_rd_q;
`endif

  // Stage 0 is the array output register; RD_LAT-1 further stages align the pulse.
  genvar gi;
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign out_vld  = vld0_q;
      assign out_data = load_data;
    end else begin : g_latn
      for (gi = 0; gi < RD_LAT - 1; gi++) begin : g_stage
        logic        vld_in, vld_q;
        logic [31:0] data_in, data_q;
        if (gi == 0) begin : g_head
          assign vld_in  = vld0_q;
          assign data_in = load_data;
        end else begin : g_tail
          assign vld_in  = g_stage[gi-1].vld_q;
          assign data_in = g_stage[gi-1].data_q;
        end
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
          end else begin
            vld_q  <= vld_in;
            data_q <= data_in;
          end
        end
      end
      assign out_vld  = g_stage[RD_LAT-2].vld_q;
      assign out_data = g_stage[RD_LAT-2].data_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rdata_hold_q <= '0;
    else if (out_vld) rdata_hold_q <= out_data;
  end

  assign rdata       = out_vld ? out_data : rdata_hold_q;
  assign rdata_valid = out_vld;
  assign err_oob     = err_oob_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder at default parameters (RD_LAT=2, ADDR_W=15).
// Inputs change and outputs are sampled 1 time unit after the falling edge.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [29:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        n_stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err_oob;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(15), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .n_stall(n_stall),
    .rdata(rdata), .rdata_valid(rdata_valid), .err_oob(err_oob)
  );

  // One cycle of stimulus; returns just after inputs settle so checks see that cycle.
  task automatic cyc(input logic v, input logic we, input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    $display("reset released");
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=00000000", rdata); end
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_rdata_valid got=%b exp=0", rdata_valid); end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL reset_err_oob got=%b exp=0", err_oob); end
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL reset_n_stall got=%b exp=1", n_stall); end
  endtask

  task automatic test_basic_load;
    $display("basic: store 0x10<=deadbeef, load 0x10");
    cyc(1, 1, 30'h10, 32'hDEADBEEF);
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL basic_store_n_stall got=%b exp=1", n_stall); end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 30'h10, 0);
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL basic_load_accept got=%b exp=1", n_stall); end
    cyc(0, 0, 0, 0);
    checks++; if (n_stall !== 1'b0) begin errors++; $display("FAIL basic_t1_n_stall got=%b exp=0", n_stall); end
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL basic_t1_valid got=%b exp=0", rdata_valid); end
    cyc(0, 0, 0, 0);
    checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL basic_t2_valid got=%b exp=1", rdata_valid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_t2_rdata got=%h exp=deadbeef", rdata); end
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL basic_t2_n_stall got=%b exp=1", n_stall); end
    cyc(0, 0, 0, 0);
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL basic_t3_valid got=%b exp=0", rdata_valid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_t3_hold got=%h exp=deadbeef", rdata); end
  endtask

  task automatic test_hazard;
    $display("hazard: store 5<=11, load 5 next cycle");
    cyc(1, 1, 30'd5, 32'h11);
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL hazard_store_n_stall got=%b exp=1", n_stall); end
    cyc(1, 0, 30'd5, 0);
`ifdef DMEM_FWD_EN
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL hazard_fwd_accept got=%b exp=1", n_stall); end
`else
    checks++; if (n_stall !== 1'b0) begin errors++; $display("FAIL hazard_stall got=%b exp=0", n_stall); end
    cyc(1, 0, 30'd5, 0);
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL hazard_retry_accept got=%b exp=1", n_stall); end
`endif
    cyc(0, 0, 0, 0);
    checks++; if (n_stall !== 1'b0) begin errors++; $display("FAIL hazard_busy got=%b exp=0", n_stall); end
    cyc(0, 0, 0, 0);
    checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL hazard_valid got=%b exp=1", rdata_valid); end
    checks++; if (rdata !== 32'h11) begin errors++; $display("FAIL hazard_rdata got=%h exp=00000011", rdata); end
  endtask

  task automatic test_back_to_back;
    $display("back_to_back: store 1<=a, 2<=b, load 1, load 2");
    cyc(1, 1, 30'd1, 32'hA);
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL b2b_store1_n_stall got=%b exp=1", n_stall); end
    cyc(1, 1, 30'd2, 32'hB);
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL b2b_store2_n_stall got=%b exp=1", n_stall); end
    cyc(1, 0, 30'd1, 0);
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL b2b_load1_accept got=%b exp=1", n_stall); end
    cyc(0, 0, 0, 0);
    cyc(1, 0, 30'd2, 0);
    checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL b2b_load1_valid got=%b exp=1", rdata_valid); end
    checks++; if (rdata !== 32'hA) begin errors++; $display("FAIL b2b_load1_rdata got=%h exp=0000000a", rdata); end
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL b2b_load2_accept got=%b exp=1", n_stall); end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL b2b_load2_valid got=%b exp=1", rdata_valid); end
    checks++; if (rdata !== 32'hB) begin errors++; $display("FAIL b2b_load2_rdata got=%h exp=0000000b", rdata); end
  endtask

  task automatic test_out_of_range;
    $display("oob: load 0x8000, store 0x8000<=ff, load 0");
    cyc(1, 1, 30'd0, 32'h12345678);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 30'h8000, 0);
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL oob_before got=%b exp=0", err_oob); end
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL oob_load_accept got=%b exp=1", n_stall); end
    cyc(0, 0, 0, 0);
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_set got=%b exp=1", err_oob); end
    cyc(1, 1, 30'h8000, 32'hFF);
    checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL oob_load_valid got=%b exp=1", rdata_valid); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL oob_load_rdata got=%h exp=00000000", rdata); end
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL oob_store_n_stall got=%b exp=1", n_stall); end
    cyc(1, 0, 30'd0, 0);
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL oob_load0_accept got=%b exp=1", n_stall); end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL oob_load0_valid got=%b exp=1", rdata_valid); end
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL oob_word0 got=%h exp=12345678", rdata); end
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_sticky got=%b exp=1", err_oob); end
  endtask

  task automatic test_reset_mid_load;
    $display("reset_mid_load: store 7<=77, buffer 7<=99, load 3, reset");
    cyc(1, 1, 30'd7, 32'h77);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 30'd7, 32'h99);
    cyc(1, 0, 30'd3, 0);
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL rml_load_accept got=%b exp=1", n_stall); end
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL rml_t1_valid got=%b exp=0", rdata_valid); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rml_rdata_cleared got=%h exp=00000000", rdata); end
    @(negedge clk);
    #1;
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL rml_t2_valid got=%b exp=0", rdata_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL rml_release_n_stall got=%b exp=1", n_stall); end
    cyc(0, 0, 0, 0);
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL rml_after_valid got=%b exp=0", rdata_valid); end
    cyc(1, 0, 30'd7, 0);
    checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL rml_load7_accept got=%b exp=1", n_stall); end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL rml_load7_valid got=%b exp=1", rdata_valid); end
    checks++; if (rdata !== 32'h77) begin errors++; $display("FAIL rml_load7_rdata got=%h exp=00000077", rdata); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_hazard();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the ALU's memory-address interface.
- Accepts one load or store per cycle from the execute stage: word address from the ALU address output, store data from the ALU result.
- Services requests from an internal single-port word array through a one-entry store buffer.
- Returns load data with fixed latency and drives n_stall back to the pipeline while a load is in flight or a hazard exists.

Parameters:
- ADDR_W, 15, word-address width of the internal array (2^ADDR_W 32-bit words)
- RD_LAT, 2, load latency in cycles from acceptance to rdata_valid; legal 1..4

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  30  word address
- req_wdata  in  32  store data
- n_stall  out  1  1 = request accepted / pipeline may advance; 0 = hold
- rdata  out  32  load result
- rdata_valid  out  1  one-cycle pulse when rdata is updated
- err_oob  out  1  sticky out-of-range flag

Behaviour:
- Reset (asynchronous, active-high):
  - rdata=0, rdata_valid=0, err_oob=0.
  - Store buffer invalid; FSM IDLE; latency counter 0.
  - n_stall=1 once rst deasserts.
  - Array contents are not reset.
- Acceptance: a request is accepted in a cycle with req_valid=1 and n_stall=1. When n_stall=0, req_valid is ignored and the requester holds its request.
- n_stall is combinational: n_stall = !busy && !hazard.
  - busy = FSM in WAIT.
  - hazard = req_valid && !req_we && sb_valid && sb_addr==req_addr[ADDR_W-1:0].
- FSM:
  - IDLE -> WAIT on load acceptance when RD_LAT>1; the counter is loaded with RD_LAT-1.
  - WAIT decrements the counter each cycle and returns to IDLE when it reaches 1.
  - RD_LAT=1: the FSM never leaves IDLE and loads never stall.
- Load accepted at cycle T:
  - Array read address is sampled at T.
  - n_stall=0 for cycles T+1 .. T+RD_LAT-1.
  - rdata and rdata_valid=1 appear at T+RD_LAT.
  - rdata holds its value until the next load completes.
- Store:
  - Accepted stores go to the store buffer (sb_valid, sb_addr, sb_data); stores never stall.
  - The buffer drains to the array in any cycle where the port is not used by a load acceptance.
  - Store accepted while the buffer is valid: the old entry is written to the array and the new entry captured in the same cycle.
  - Load acceptance has priority over draining; the buffer holds its entry meanwhile.
- Hazard (load to the buffered address): n_stall=0 for one cycle while the buffer drains; the load is accepted the next cycle.
- Out of range (req_addr[29:ADDR_W] != 0) on an accepted request:
  - err_oob sets on the next edge and stays set until reset.
  - A store is discarded.
  - A load returns 0 with normal latency and pulse.
- Address width: req_addr bits [ADDR_W-1:0] index the array; there is no wrap-around aliasing because out-of-range addresses are rejected.
- Reset mid-operation: a pending load is aborted (no rdata_valid pulse) and a buffered store is lost.

Optional Feature:
- Macro: DMEM_FWD_EN.
- Defined:
  - A load whose address matches a valid buffer entry is accepted immediately (no hazard term in n_stall).
  - It returns sb_data as captured at acceptance, with normal RD_LAT latency.
  - The buffer is not drained that cycle.
- Undefined: the hazard stall described above applies.

Test Plan:
- Reset: rst=1 for 3 cycles, then 0 -> rdata=0, rdata_valid=0, err_oob=0, n_stall=1.
- Basic load (RD_LAT=2): store addr 0x10 <= 0xDEADBEEF, 2 idle cycles, load 0x10 at T -> n_stall=0 at T+1; rdata=0xDEADBEEF with rdata_valid=1 at T+2; rdata_valid=0 at T+3.
- Store-then-load hazard: store addr 5 <= 0x11, load addr 5 next cycle.
  - Without DMEM_FWD_EN: n_stall=0 in the load cycle; load accepted one cycle later; rdata=0x11.
  - With DMEM_FWD_EN: load accepted immediately; rdata=0x11 two cycles later.
- Back-to-back stores: stores 1<=0xA, 2<=0xB on consecutive cycles, then loads 1 and 2 -> rdata 0xA then 0xB; no stall on the stores.
- Out of range: load 0x8000 -> err_oob=1 from the next edge, rdata=0 at T+2. Then store 0x8000 <= 0xFF and load 0 -> word 0 unchanged; err_oob stays 1.
- Reset mid-load: assert rst at T+1 of a load -> no rdata_valid pulse; n_stall=1 after release. A store buffered before reset is lost: a load of that address returns the prior array contents.
